// File: rtl/softmax_out_writer_pkg.sv
// Shared definitions for the softmax output writer: datapath widths,
// default buffer depth, FSM state encoding and small helpers.
package softmax_out_writer_pkg;

    localparam int DATAWIDTH          = 16;
    localparam int NUM                = 4;
    localparam int ADDRSIZE           = 8;
    localparam int WORDWIDTH          = DATAWIDTH * NUM;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef logic [ADDRSIZE-1:0]  addr_t;
    typedef logic [WORDWIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A run with no words to write: end address at or below the start.
    function automatic logic run_is_empty(input addr_t start_a, input addr_t end_a);
        return (end_a <= start_a);
    endfunction

endpackage

// File: rtl/softmax_out_writer_fifo.sv
// out_fifo: small synchronous FIFO between the softmax result capture and the
// memory write port. Registered storage, read/write pointers one bit wider
// than the index so full and empty are told apart by the extra bit.
// A push while full is accepted only when a pop happens in the same cycle.
module out_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify requests; flush wins over both.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i) && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/softmax_out_writer.sv
// softmax_out_writer: captures softmax result words on each done pulse,
// buffers them in out_fifo and drains them to the output memory through a
// valid/ready write port with an auto-incrementing address. all_done is a
// sticky flag raised once the expected word count has been written.
// Build option: OUT_WRITER_OVERFLOW_EN enables the sticky overflow flag;
// without it the overflow port is tied low (words are still dropped).
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | after reset, waiting for init; in_valid ignored
//   RUN     | capturing words and writing them to memory
//   DONE    | expected count written (or empty run); waiting for init
module softmax_out_writer
    import softmax_out_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [ADDRSIZE-1:0]  start_addr,
    input  logic [ADDRSIZE-1:0]  end_addr,
    input  logic                 in_valid,
    input  logic [WORDWIDTH-1:0] in_data,
    input  logic                 wr_ready,
    output logic                 wr_en,
    output logic [ADDRSIZE-1:0]  wr_addr,
    output logic [WORDWIDTH-1:0] wr_data,
    output logic                 overflow,
    output logic                 all_done
);

    state_e state_q, state_d;

    addr_t  wr_addr_q, wr_addr_d;
    addr_t  word_cnt_q, word_cnt_d;
    addr_t  pushed_q, pushed_d;
    addr_t  written_q, written_d;
    logic   done_q, done_d;

    logic   fifo_full;
    logic   fifo_empty;
    word_t  fifo_head;

    logic   run;
    logic   pop;
    logic   room;
    logic   quota_left;
    logic   push;
    logic   last_xfer;
    logic   empty_run;

    out_fifo #(
        .DW    (WORDWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (init),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: init from any state (re)starts a run.
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = empty_run ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN && last_xfer) begin
            state_d = ST_DONE;
        end
    end

    // FSM outputs and transfer/push qualification.
    always_comb begin
        run        = (state_q == ST_RUN);
        wr_en      = run && !fifo_empty;
        pop        = wr_en && wr_ready;
        // A slot freed by a same-cycle pop can take the incoming word.
        room       = !fifo_full || pop;
        quota_left = (pushed_q != word_cnt_q);
        push       = run && !init && in_valid && room && quota_left;
        last_xfer  = pop && !init && ((written_q + ADDRSIZE'(1)) == word_cnt_q);
        empty_run  = run_is_empty(start_addr, end_addr);
    end

    // Address, word counters and completion flag next-state.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        word_cnt_d = word_cnt_q;
        pushed_d   = pushed_q;
        written_d  = written_q;
        done_d     = done_q;
        if (init) begin
            wr_addr_d  = start_addr;
            word_cnt_d = end_addr - start_addr;
            pushed_d   = '0;
            written_d  = '0;
            done_d     = empty_run;
        end else begin
            if (push) pushed_d = pushed_q + ADDRSIZE'(1);
            if (pop) begin
                wr_addr_d = wr_addr_q + ADDRSIZE'(1);
                written_d = written_q + ADDRSIZE'(1);
            end
            if (last_xfer) done_d = 1'b1;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q  <= '0;
            word_cnt_q <= '0;
            pushed_q   <= '0;
            written_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            word_cnt_q <= word_cnt_d;
            pushed_q   <= pushed_d;
            written_q  <= written_d;
            done_q     <= done_d;
        end
    end

`ifdef OUT_WRITER_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic drop;

    // A valid word in RUN that could not be pushed is a drop.
    always_comb begin
        drop  = run && !init && in_valid && !(room && quota_left);
        ovf_d = ovf_q;
        if (init)      ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign wr_addr  = wr_addr_q;
    assign wr_data  = fifo_head;
    assign all_done = done_q;

endmodule

// File: tb/tb_softmax_out_writer.sv
// Testbench for softmax_out_writer: directed scenarios plus randomized runs.
// A behavioural model at posedge tracks run mode, buffered word count and
// accepted/written counts, pushing each accepted word's {addr,data} into a
// scoreboard queue; a negedge monitor compares the write port against it.
module tb_softmax_out_writer;
    import softmax_out_writer_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } wr_t;

    logic  clk = 1'b0;
    logic  reset, init, in_valid, wr_ready;
    addr_t start_addr, end_addr;
    word_t in_data;
    logic  wr_en, overflow, all_done;
    addr_t wr_addr;
    word_t wr_data;

    softmax_out_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .overflow   (overflow),
        .all_done   (all_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int    m_mode = M_IDLE;
    int    m_occ = 0, m_acc = 0, m_wr = 0, m_cnt = 0;
    addr_t m_base = '0;
    bit    m_ovf = 0, m_done = 0, m_rst_state = 1, armed = 0;
    wr_t   sb[$];

    always @(posedge clk) begin
        bit xfer;
        if (reset) begin
            armed = 1; m_mode = M_IDLE; m_occ = 0; m_ovf = 0; m_done = 0;
            m_rst_state = 1; sb.delete();
        end else if (init) begin
            sb.delete();
            m_rst_state = 0; m_occ = 0; m_acc = 0; m_wr = 0; m_ovf = 0;
            m_base = start_addr;
            if (int'(end_addr) <= int'(start_addr)) begin
                m_mode = M_DONE; m_done = 1; m_cnt = 0;
            end else begin
                m_mode = M_RUN; m_done = 0; m_cnt = int'(end_addr) - int'(start_addr);
            end
        end else if (m_mode == M_RUN) begin
            xfer = (m_occ > 0) && wr_ready;
            if (in_valid) begin
                if ((m_occ < DEPTH || xfer) && m_acc < m_cnt) begin
                    sb.push_back('{addr: addr_t'(int'(m_base) + m_acc), data: in_data});
                    m_acc++; m_occ++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (xfer) begin
                m_occ--; m_wr++;
                if (m_wr == m_cnt) begin m_mode = M_DONE; m_done = 1; end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (armed && !reset) begin
            check("wr_en", wr_en, (m_mode == M_RUN && m_occ > 0));
            check("all_done", all_done, m_done);
`ifdef OUT_WRITER_OVERFLOW_EN
            check("overflow", overflow, m_ovf);
`else
            check("overflow", overflow, 0);
`endif
            if (m_rst_state) begin
                check("rst_wr_addr", wr_addr, 0);
                check("rst_wr_data", wr_data, 0);
            end
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", wr_addr, sb[0].addr);
                    check("wr_data", wr_data, sb[0].data);
                    if (wr_ready) begin
                        void'(sb.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_init(input addr_t s, input addr_t e);
        start_addr = s; end_addr = e; init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic push_word(input word_t d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic word_t rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int x0;
        reset = 1'b1; init = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
        start_addr = '0; end_addr = '0; in_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        in_valid = 1'b1; in_data = rnd_word(); wr_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;

        // Basic run
        wr_ready = 1'b1;
        do_init(8'h10, 8'h14);
        for (int i = 0; i < 4; i++)
            push_word(64'h0001_0002_0003_0004 + 64'(i) * 64'h0001_0001_0001_0001);
        tick();
        check("basic_all_done", all_done, 1);
        repeat (2) tick();

        // Backpressure mid-stream
        do_init(8'h20, 8'h24);
        push_word(rnd_word());
        wr_ready = 1'b0;
        push_word(rnd_word());
        push_word(rnd_word());
        tick();
        wr_ready = 1'b1;
        push_word(rnd_word());
        repeat (4) tick();
        check("bp_all_done", all_done, 1);

        // Overflow: six words into a stalled depth-4 buffer
        wr_ready = 1'b0;
        do_init(8'h30, 8'h3A);
        for (int i = 0; i < 6; i++) push_word(rnd_word());
        x0 = n_xfer;
        wr_ready = 1'b1;
        repeat (6) tick();
        check("ovf_written_words", n_xfer - x0, 4);
        for (int i = 0; i < 6; i++) push_word(rnd_word());
        repeat (3) tick();
        check("ovf_run_done", all_done, 1);

        // Full buffer with simultaneous push and pop
        wr_ready = 1'b0;
        do_init(8'h50, 8'h58);
        for (int i = 0; i < 4; i++) push_word(rnd_word());
        wr_ready = 1'b1;
        push_word(rnd_word());
        wr_ready = 1'b0;
        tick();
        x0 = n_xfer;
        wr_ready = 1'b1;
        repeat (6) tick();
        check("full_pushpop_occ", n_xfer - x0, 4);
        for (int i = 0; i < 3; i++) push_word(rnd_word());
        repeat (3) tick();
        check("full_run_done", all_done, 1);

        // Restart mid-run after a count-exceeded drop
        wr_ready = 1'b0;
        do_init(8'h60, 8'h62);
        for (int i = 0; i < 3; i++) push_word(rnd_word());
        tick();
        do_init(8'h40, 8'h44);
        check("restart_flush", wr_en, 0);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(rnd_word());
        repeat (3) tick();

        // Degenerate runs
        do_init(8'h70, 8'h70);
        check("degen_done", all_done, 1);
        push_word(rnd_word());
        repeat (2) tick();
        do_init(8'h80, 8'h7F);
        check("degen2_done", all_done, 1);
        tick();

        // Reset mid-run, together with init and in_valid
        wr_ready = 1'b0;
        do_init(8'h90, 8'h98);
        push_word(rnd_word());
        push_word(rnd_word());
        reset = 1'b1; init = 1'b1; in_valid = 1'b1; start_addr = 8'hA0; end_addr = 8'hA8;
        tick();
        reset = 1'b0; init = 1'b0; in_valid = 1'b0;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_all_done", all_done, 0);
        check("rst_mid_overflow", overflow, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        wr_ready = 1'b1;
        repeat (3) tick();

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            int s, len, e, budget;
            s   = $urandom_range(0, 250);
            len = $urandom_range(1, 14);
            e   = (s + len > 255) ? 255 : s + len;
            do_init(addr_t'(s), addr_t'(e));
            budget = 400;
            while (!all_done && budget > 0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rnd_word();
                wr_ready = ($urandom_range(0, 3) != 0);
                tick();
                budget--;
            end
            in_valid = 1'b0;
            if (budget == 0) check("rand_timeout", all_done, 1);
            repeat (2) tick();
        end

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/softmax_out_writer.md
# softmax_out_writer

Downstream writeback stage for the softmax pipeline. Captures the four-lane result word presented on each cycle the softmax `done` pulse is high and buffers it in a small FIFO. Drains the FIFO into the on-chip output memory through a valid/ready write port with an auto-incrementing address. Raises a sticky completion flag once the expected number of words has been written.

## Interface
- DATAWIDTH, 16, width of one fixed-point lane
- NUM, 4, lanes per word
- ADDRSIZE, 8, memory address width
- FIFO_DEPTH, 4, buffer entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- init  in  1  latch `start_addr`/`end_addr`, flush FIFO, enter RUN
- start_addr  in  ADDRSIZE  first write address; also the first source address of the softmax run
- end_addr  in  ADDRSIZE  one past the last address; word count = end_addr − start_addr
- in_valid  in  1  softmax `done` pulse; result word valid this cycle
- in_data  in  DATAWIDTH*NUM  {outp3,outp2,outp1,outp0}, lane 0 in the LSBs
- wr_ready  in  1  memory accepts the write this cycle
- wr_en  out  1  write request
- wr_addr  out  ADDRSIZE  write address
- wr_data  out  DATAWIDTH*NUM  write data (FIFO head)
- overflow  out  1  sticky: a word was dropped
- all_done  out  1  sticky: all expected words written

## Operation
- States: IDLE (after reset), RUN, DONE.
  - IDLE→RUN on init.
  - RUN→DONE on the transfer of the last expected word.
  - DONE→RUN on init.
  - init while in RUN restarts the run: FIFO flushed, counters reloaded, overflow cleared.
- In RUN, each in_valid pushes in_data, unless the FIFO is full or pushed count already equals the word count. In either case the word is dropped and overflow is set.
- in_valid in IDLE or DONE is ignored; overflow is unaffected.
- wr_en = RUN and FIFO not empty. A transfer occurs when wr_en & wr_ready. On transfer: pop the FIFO, wr_addr += 1, written count += 1.
- wr_addr is loaded with start_addr on init.
- Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot and occupancy is unchanged.
- Degenerate run: if end_addr ≤ start_addr at init, go straight to DONE with all_done = 1 the next cycle; no writes occur.
- Counters are ADDRSIZE bits. The address wraps modulo 2^ADDRSIZE. No other arithmetic is performed.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, overflow 0, all_done 0; state IDLE; FIFO empty.
- Latency: a word pushed at edge N appears as wr_en=1 with that wr_data in the cycle after edge N. Earliest memory write is one cycle after in_valid.
- wr_data and wr_addr are stable while wr_en=1 and wr_ready=0.
- Sustained throughput is one word per cycle with wr_ready held high. The FIFO absorbs up to FIFO_DEPTH cycles of wr_ready=0 while words keep arriving.
- all_done rises in the cycle after the last transfer. It holds until init or reset.
- overflow rises in the cycle after the dropped push.
- reset mid-run overrides init and in_valid in the same cycle; all state returns to reset values.

## Configuration
- OUT_WRITER_OVERFLOW_EN defined: overflow detection logic present, behaving as described above.
- OUT_WRITER_OVERFLOW_EN undefined: the overflow port is tied to 0. Dropping behaviour is unchanged, so words are still discarded when the FIFO is full or the count is exceeded.

## Structure
- The shared defines file holds DATAWIDTH, NUM, ADDRSIZE and the state encodings (IDLE=0, RUN=1, DONE=2).
- Sub-module `out_fifo`: synchronous FIFO with push, pop, full, empty and head. It is registered storage with pointers one bit wider than log2(FIFO_DEPTH).
- Top level holds the FSM, address and word counters, and the sticky flags.

## Test plan
- Basic run: start_addr=0x10, end_addr=0x14, wr_ready=1, four in_valid words 0x0001_0002_0003_0004 … → writes to 0x10..0x13 in order, each one cycle after its in_valid; all_done=1 in the cycle after the 0x13 write.
- Backpressure: same run with wr_ready=0 for 3 cycles mid-stream → no loss; wr_addr/wr_data held while stalled; overflow stays 0.
- Overflow: FIFO_DEPTH=4, wr_ready=0, six consecutive in_valid → four words buffered; overflow=1 one cycle after the 5th; after release exactly four words are written.
- Full with simultaneous push/pop: FIFO full, wr_ready=1 and in_valid=1 in the same cycle → no drop; occupancy remains 4.
- Restart: init asserted mid-run with new start_addr=0x40 → FIFO flushed; next write goes to 0x40; overflow and all_done cleared.
- Edge cases:
  - Degenerate run with end_addr=start_addr → all_done=1 one cycle after init, wr_en never asserted.
  - reset asserted mid-run → all outputs return to 0 on the next edge.
